// File: rtl/input_block_buffer_if.sv
// input_block_buffer_if: word-stream, block-stream and status signals between the AHB master, the buffer and the AES core
//   clear        flush of packer and FIFO
//   shift_en     word strobe,  shiftin  32-bit word,  end_block  last-word marker
//   block_ready  AES core accepts the head block
//   block_valid  head block present,  block_data  128-bit head,  block_last  head ends the transfer
//   fetch_enable master enable,  word_count  words in the packer,  overflow  sticky dropped-word flag
interface input_block_buffer_if;
  logic         clear;
  logic         shift_en;
  logic [31:0]  shiftin;
  logic         end_block;
  logic         block_ready;
  logic         block_valid;
  logic [127:0] block_data;
  logic         block_last;
  logic         fetch_enable;
  logic [1:0]   word_count;
  logic         overflow;
  modport master (
    output clear, shift_en, shiftin, end_block, block_ready,
    input  block_valid, block_data, block_last, fetch_enable, word_count, overflow
  );
  modport slave (
    input  clear, shift_en, shiftin, end_block, block_ready,
    output block_valid, block_data, block_last, fetch_enable, word_count, overflow
  );
endinterface

// File: rtl/input_block_buffer.sv
// input_block_buffer: packs 32-bit words into 128-bit blocks and queues them in a 2-entry FIFO
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    input_block_buffer_if.slave carrying the word input, block output and status
module input_block_buffer (
  input logic clk,
  input logic n_rst,
  input_block_buffer_if.slave bus
);
  logic [3:0][31:0] pk_w, words_nx;
  logic             pk_last, pk_full, last_nx, full_nx;
  logic [1:0]       wc, wc_nx;
  logic [127:0]     mem_d [2];
  logic             mem_l [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_count, fifo_nx;
  logic             ovf, fetch_en;
  logic             pop, commit, accept, fill, drop;
  // A committing packer frees itself in the same edge, so a word arriving
  // in the commit cycle starts the next block instead of being dropped.
  always_comb begin
    pop      = (fifo_count != 2'd0) && bus.block_ready;
    commit   = pk_full && ((fifo_count != 2'd2) || pop);
    accept   = bus.shift_en && (!pk_full || commit);
    drop     = bus.shift_en && pk_full && !commit;
    fill     = accept && ((wc == 2'd3) || bus.end_block);
    fifo_nx  = fifo_count + 2'(commit) - 2'(pop);
    full_nx  = fill || (pk_full && !commit);
    last_nx  = fill ? bus.end_block : (commit ? 1'b0 : pk_last);
    wc_nx    = fill ? 2'd0 : (accept ? wc + 2'd1 : wc);
    words_nx = commit ? '0 : pk_w;
    if (accept) words_nx[2'd3 - wc] = bus.shiftin;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pk_w       <= '0;
      pk_last    <= 1'b0;
      pk_full    <= 1'b0;
      wc         <= 2'd0;
      mem_d      <= '{default: '0};
      mem_l      <= '{default: 1'b0};
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      ovf        <= 1'b0;
      fetch_en   <= 1'b1;
    end else if (bus.clear) begin
      pk_w       <= '0;
      pk_last    <= 1'b0;
      pk_full    <= 1'b0;
      wc         <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      ovf        <= 1'b0;
      fetch_en   <= 1'b1;
    end else begin
      pk_w       <= words_nx;
      pk_last    <= last_nx;
      pk_full    <= full_nx;
      wc         <= wc_nx;
      fifo_count <= fifo_nx;
      ovf        <= ovf || drop;
      fetch_en   <= (fifo_nx == 2'd0) || ((fifo_nx == 2'd1) && !full_nx);
      if (commit) begin
        mem_d[wr_ptr] <= pk_w;
        mem_l[wr_ptr] <= pk_last;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
  assign bus.block_valid  = fifo_count != 2'd0;
  assign bus.block_data   = mem_d[rd_ptr];
  assign bus.block_last   = mem_l[rd_ptr];
  assign bus.word_count   = wc;
  assign bus.overflow     = ovf;
  assign bus.fetch_enable = fetch_en;
endmodule

// File: tb/tb_input_block_buffer.sv
// tb_input_block_buffer: directed and random checks of input_block_buffer against a queue-based model
module tb_input_block_buffer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
  input_block_buffer_if bus ();
  input_block_buffer dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } blk_t;
  blk_t        q[$];
  logic [31:0] pw [4];
  int          pn;
  logic        pfull, plast, movf, mfetch;
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) pw[i] = '0;
    pn = 0;
    pfull = 1'b0;
    plast = 1'b0;
    movf = 1'b0;
    mfetch = 1'b1;
  endtask
  // One clock of behaviour: the consumer takes the head, a waiting block moves
  // into any free slot, then the incoming word lands in the (possibly freed) packer.
  task automatic model_update(input logic se, input logic [31:0] d, input logic eb, input logic rdy, input logic clr);
    logic popped;
    if (clr) begin
      model_reset();
      return;
    end
    popped = (q.size() > 0) && rdy;
    if (popped) void'(q.pop_front());
    if (pfull && q.size() < 2) begin
      q.push_back('{d: {pw[0], pw[1], pw[2], pw[3]}, l: plast});
      for (int i = 0; i < 4; i++) pw[i] = '0;
      pfull = 1'b0;
      plast = 1'b0;
    end
    if (se) begin
      if (pfull) movf = 1'b1;
      else begin
        pw[pn] = d;
        pn++;
        if (pn == 4 || eb) begin
          pfull = 1'b1;
          plast = eb;
          pn = 0;
        end
      end
    end
    mfetch = (q.size() == 0) || (q.size() == 1 && !pfull);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    chk("block_valid", 128'(bus.block_valid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      chk("block_data", bus.block_data, q[0].d);
      chk("block_last", 128'(bus.block_last), 128'(q[0].l));
    end
    chk("word_count", 128'(bus.word_count), 128'(pn));
    chk("overflow", 128'(bus.overflow), 128'(movf));
    chk("fetch_enable", 128'(bus.fetch_enable), 128'(mfetch));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 128'(bus.block_valid), 128'(0));
    chk({tag, "_data"}, bus.block_data, 128'(0));
    chk({tag, "_last"}, 128'(bus.block_last), 128'(0));
    chk({tag, "_wc"}, 128'(bus.word_count), 128'(0));
    chk({tag, "_ovf"}, 128'(bus.overflow), 128'(0));
    chk({tag, "_fetch"}, 128'(bus.fetch_enable), 128'(1));
  endtask
  task automatic step(input logic se, input logic [31:0] d, input logic eb, input logic rdy, input logic clr);
    bus.shift_en = se;
    bus.shiftin = d;
    bus.end_block = eb;
    bus.block_ready = rdy;
    bus.clear = clr;
    @(posedge clk);
    model_update(se, d, eb, rdy, clr);
    #1;
    check_model();
  endtask
  task automatic burst(input int n, input logic [31:0] base);
    for (int i = 1; i <= n; i++) step(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.shift_en = 1'b0;
    bus.shiftin = '0;
    bus.end_block = 1'b0;
    bus.block_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;
    // full block, ready asserted
    step(1'b1, 32'h00112233, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h44556677, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h8899AABB, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hCCDDEEFF, 1'b0, 1'b1, 1'b0);
    chk("full_not_yet_valid", 128'(bus.block_valid), 128'(0));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("full_valid", 128'(bus.block_valid), 128'(1));
    chk("full_data", bus.block_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("full_last", 128'(bus.block_last), 128'(0));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("full_popped", 128'(bus.block_valid), 128'(0));
    // short last block
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h01234567, 1'b1, 1'b0, 1'b0);
    chk("short_wc", 128'(bus.word_count), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("short_data", bus.block_data, 128'hDEADBEEF_01234567_00000000_00000000);
    chk("short_last", 128'(bus.block_last), 128'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("short_held", bus.block_data, 128'hDEADBEEF_01234567_00000000_00000000);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    // backpressure: 12 words, then a 13th that must be dropped
    burst(12, 32'h1000_0000);
    chk("bp_fetch_low", 128'(bus.fetch_enable), 128'(0));
    step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0);
    chk("bp_overflow", 128'(bus.overflow), 128'(1));
    // simultaneous pop and commit keeps two blocks queued
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pushpop_head", bus.block_data, 128'h10000005_10000006_10000007_10000008);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pushpop_kept", bus.block_data, 128'h10000009_1000000A_1000000B_1000000C);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pushpop_drained", 128'(bus.block_valid), 128'(0));
    // clear with overflow set and blocks queued
    burst(13, 32'h2000_0000);
    chk("clr_pre_ovf", 128'(bus.overflow), 128'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_valid", 128'(bus.block_valid), 128'(0));
    chk("clr_ovf", 128'(bus.overflow), 128'(0));
    chk("clr_wc", 128'(bus.word_count), 128'(0));
    chk("clr_fetch", 128'(bus.fetch_enable), 128'(1));
    // reset in the middle of a block
    burst(3, 32'h3000_0000);
    n_rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    n_rst = 1'b1;
    burst(4, 32'h4000_0000);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("midrst_block", bus.block_data, 128'h40000001_40000002_40000003_40000004);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("midrst_only_one", 128'(bus.block_valid), 128'(0));
    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
